// File: rtl/task_sched_pkg.sv
// Shared scheduler/dispatcher types: task IDs, dispatcher states, default task count.
package task_sched_pkg;

  typedef logic [31:0] task_id_t;

  localparam task_id_t TASK_ID_NONE      = '0;
  localparam int       DEFAULT_NUM_TASKS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } dispatch_state_e;

  // A release is dispatchable only if it names one of tasks 1..num_tasks.
  function automatic logic id_valid(input task_id_t id, input int unsigned num_tasks);
    return (id != TASK_ID_NONE) && (id <= task_id_t'(num_tasks));
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Release FIFO: head visible combinationally, push/pop take effect at the edge.
// No internal backpressure; the parent only pushes when not full or popping in the same cycle.
module dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: occupancy is defined solely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;

endmodule

// File: rtl/task_dispatcher.sv
// Queues scheduler releases and runs them one at a time on a worker; start follows a release by 2 clocks.
// Full queue drops releases (counted); optional run watchdog under TASK_DISPATCH_WATCHDOG_EN.
module task_dispatcher
  import task_sched_pkg::*;
#(
  parameter int NUM_TASKS   = DEFAULT_NUM_TASKS,
  parameter int QUEUE_DEPTH = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  task_id_t                     task_id_in,
  output logic                         worker_start,
  output task_id_t                     worker_task_id,
  input  logic                         worker_done,
  output logic                         busy,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count,
  output logic [15:0]                  drop_count,
  output logic                         overrun
);

  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
    $error("task_dispatcher: QUEUE_DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
  end

  dispatch_state_e state;
  task_id_t        fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic            drop;

  // A full queue still accepts a release in the cycle the FSM pops it.
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign fifo_push = id_valid(task_id_in, NUM_TASKS) && (!fifo_full || fifo_pop);
  assign drop      = (task_id_in != TASK_ID_NONE) && !fifo_push;

  dispatch_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH ($bits(task_id_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (task_id_in),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (queue_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (drop && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end

`ifdef TASK_DISPATCH_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT);
  logic [WDW-1:0] wd_cnt;
`else
  assign overrun = 1'b0;
`endif

  // overrun is registered, so the expiry decision taken in the last RUN cycle
  // appears together with the return to IDLE; a same-cycle done suppresses it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      worker_start   <= 1'b0;
      worker_task_id <= TASK_ID_NONE;
      busy           <= 1'b0;
`ifdef TASK_DISPATCH_WATCHDOG_EN
      wd_cnt         <= '0;
      overrun        <= 1'b0;
`endif
    end else begin
      worker_start <= 1'b0;
`ifdef TASK_DISPATCH_WATCHDOG_EN
      overrun      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            worker_task_id <= fifo_head;
            worker_start   <= 1'b1;
            busy           <= 1'b1;
            state          <= START;
          end
        end
        START: begin
          state <= RUN;
`ifdef TASK_DISPATCH_WATCHDOG_EN
          wd_cnt <= '0;
`endif
        end
        RUN: begin
          if (worker_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
`ifdef TASK_DISPATCH_WATCHDOG_EN
          else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
            busy    <= 1'b0;
            overrun <= 1'b1;
            state   <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_task_dispatcher.sv
// Directed bench for task_dispatcher: vector table plus reset and watchdog sequences.
module tb_task_dispatcher;
  import task_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  task_id_t    task_id_in = '0;
  logic        worker_done = 1'b0;
  logic        worker_start;
  task_id_t    worker_task_id;
  logic        busy;
  logic [2:0]  queue_count;
  logic [15:0] drop_count;
  logic        overrun;

  int n_vec = 0;
  int n_bad = 0;

  task_dispatcher #(.NUM_TASKS(3), .QUEUE_DEPTH(4), .TIMEOUT(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .task_id_in     (task_id_in),
    .worker_start   (worker_start),
    .worker_task_id (worker_task_id),
    .worker_done    (worker_done),
    .busy           (busy),
    .queue_count    (queue_count),
    .drop_count     (drop_count),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got hang want finish");
    $fatal(1, "time limit");
  end

  typedef struct {
    task_id_t id;
    logic     done;
    logic     s;
    task_id_t t;
    logic     b;
    int       q;
    int       d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input task_id_t id, input logic done, input logic s,
                              input task_id_t t, input logic b, input int q, input int d);
    vec_t v;
    v.id = id; v.done = done; v.s = s; v.t = t; v.b = b; v.q = q; v.d = d;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic s, input task_id_t t, input logic b,
                         input int q, input int d, input logic o);
    chk({nm, ".worker_start"},   32'(worker_start),   32'(s));
    chk({nm, ".worker_task_id"}, worker_task_id,      t);
    chk({nm, ".busy"},           32'(busy),           32'(b));
    chk({nm, ".queue_count"},    32'(queue_count),    q);
    chk({nm, ".drop_count"},     32'(drop_count),     d);
    chk({nm, ".overrun"},        32'(overrun),        32'(o));
  endtask

  initial begin
    // Row i: inputs driven for one cycle, outputs expected after the sampling edge.
    // Single release, stray done in IDLE/START, done in 5th RUN cycle.
    tbl.push_back(mk(2, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2, 0, 0, 0));
    // Start a run on ID 3, then overflow with 1,2,3,1,2, then invalid IDs.
    tbl.push_back(mk(3, 0, 0, 2, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 3, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 3, 1, 1, 0));
    tbl.push_back(mk(2, 0, 0, 3, 1, 2, 0));
    tbl.push_back(mk(3, 0, 0, 3, 1, 3, 0));
    tbl.push_back(mk(1, 0, 0, 3, 1, 4, 0));
    tbl.push_back(mk(2, 0, 0, 3, 1, 4, 1));
    tbl.push_back(mk(7, 0, 0, 3, 1, 4, 2));
    tbl.push_back(mk(32'h8000_0001, 0, 0, 3, 1, 4, 3));
    tbl.push_back(mk(0, 1, 0, 3, 0, 4, 3));
    // Full queue: release lands on the IDLE pop and is accepted.
    tbl.push_back(mk(2, 0, 1, 1, 1, 4, 3));
    tbl.push_back(mk(0, 0, 0, 1, 1, 4, 3));
    tbl.push_back(mk(0, 1, 0, 1, 0, 4, 3));
    // Drain: expected order 2,3,1,2.
    tbl.push_back(mk(0, 0, 1, 2, 1, 3, 3));
    tbl.push_back(mk(0, 0, 0, 2, 1, 3, 3));
    tbl.push_back(mk(0, 1, 0, 2, 0, 3, 3));
    tbl.push_back(mk(0, 0, 1, 3, 1, 2, 3));
    tbl.push_back(mk(0, 0, 0, 3, 1, 2, 3));
    tbl.push_back(mk(0, 1, 0, 3, 0, 2, 3));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 3));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 3));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 3));
    tbl.push_back(mk(0, 0, 1, 2, 1, 0, 3));
    tbl.push_back(mk(0, 0, 0, 2, 1, 0, 3));
    tbl.push_back(mk(0, 1, 0, 2, 0, 0, 3));

    repeat (3) @(negedge clk);
    chk_all("reset_init", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk_all("post_reset", 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      task_id_in  = tbl[i].id;
      worker_done = tbl[i].done;
      @(negedge clk);
      chk_all($sformatf("row%0d", i), tbl[i].s, tbl[i].t, tbl[i].b, tbl[i].q, tbl[i].d, 1'b0);
    end
    task_id_in = 0; worker_done = 0;

    // Reset mid-stream: two releases still queued behind a running task.
    task_id_in = 1; @(negedge clk);
    task_id_in = 2; @(negedge clk);
    task_id_in = 3; @(negedge clk);
    task_id_in = 0;
    chk("pre_reset.queue_count", 32'(queue_count), 2);
    chk("pre_reset.busy", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk_all("mid_reset", 0, 0, 0, 0, 0, 0);
    worker_done = 1'b1;
    repeat (2) @(negedge clk);
    chk_all("reset_done_ignored", 0, 0, 0, 0, 0, 0);
    worker_done = 1'b0;
    reset = 1'b1;
    task_id_in = 1;
    @(negedge clk);
    task_id_in = 0;
    chk_all("after_reset_push", 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk_all("after_reset_start", 1, 1, 1, 0, 0, 0);
    @(negedge clk);
    worker_done = 1'b1;
    @(negedge clk);
    worker_done = 1'b0;
    chk_all("after_reset_done", 0, 1, 0, 0, 0, 0);

`ifdef TASK_DISPATCH_WATCHDOG_EN
    // Expiry: no done for 16 RUN cycles.
    task_id_in = 2; @(negedge clk);
    task_id_in = 0; @(negedge clk);
    chk("wd1.start", 32'(worker_start), 1);
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("wd1.run%0d.overrun", k), 32'(overrun), 0);
      chk($sformatf("wd1.run%0d.busy", k), 32'(busy), 1);
      @(negedge clk);
    end
    chk("wd1.expired.overrun", 32'(overrun), 1);
    chk("wd1.expired.busy", 32'(busy), 0);
    @(negedge clk);
    chk("wd1.after.overrun", 32'(overrun), 0);
    chk("wd1.after.start", 32'(worker_start), 0);

    // Done on the 16th RUN cycle beats expiry.
    task_id_in = 3; @(negedge clk);
    task_id_in = 0; @(negedge clk);
    chk("wd2.start", 32'(worker_start), 1);
    chk("wd2.tid", worker_task_id, 3);
    @(negedge clk);
    repeat (15) @(negedge clk);
    worker_done = 1'b1;
    @(negedge clk);
    worker_done = 1'b0;
    chk("wd2.done.overrun", 32'(overrun), 0);
    chk("wd2.done.busy", 32'(busy), 0);
    @(negedge clk);
    chk("wd2.after.overrun", 32'(overrun), 0);
`else
    // Without the watchdog a run waits indefinitely for done.
    task_id_in = 2; @(negedge clk);
    task_id_in = 0;
    repeat (40) @(negedge clk);
    chk("nowd.busy_held", 32'(busy), 1);
    chk("nowd.overrun", 32'(overrun), 0);
    worker_done = 1'b1;
    @(negedge clk);
    worker_done = 1'b0;
    chk("nowd.done.busy", 32'(busy), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
